clocks: RTL and testbench
=========================

CLOCKS -- requirements
Module: clocks

Interface
REQ-001 The block SHALL have parameter US, 6 bits, default 50: clk cycles per microsecond tick.
REQ-002 The block SHALL have parameter MS, 16 bits, default 50000: clk cycles per millisecond tick.
REQ-003 The block SHALL have parameter LOCK_CYCLES, 8 bits, default 4: clk cycles from reset release to lock.
REQ-004 The block SHALL have parameter PCLK_HALF, 4 bits, default 1: clk cycles per pixel-clock half period.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port pll_locked, output, 1 bit: high once the pixel clock is valid.
REQ-008 The block SHALL have port pll_outclk_0, output, 1 bit: pixel clock, a behavioural PLL stand-in.
REQ-009 The block SHALL have port us_tck, output, 1 bit: one-clk-cycle pulse, once per US cycles.
REQ-010 The block SHALL have port ms_tck, output, 1 bit: one-clk-cycle pulse, once per MS cycles.

Function
REQ-011 The lock counter SHALL start at 0 and increment on each rising edge after reset release.
REQ-012 When the lock counter equals LOCK_CYCLES, pll_locked SHALL go high on that edge and stay high until reset; LOCK_CYCLES=0 locks on the first edge.
REQ-013 While pll_locked is low, pll_outclk_0 SHALL be held 0.
REQ-014 While pll_locked is high, a half-period counter SHALL run and pll_outclk_0 SHALL toggle every PCLK_HALF edges; the output is registered, 50% duty, period 2*PCLK_HALF cycles; PCLK_HALF=0 is treated as 1.
REQ-015 The us counter (6 bits) SHALL behave as follows on each enabled edge:
- if it equals US-1, it SHALL wrap to 0 and us_tck SHALL be registered to 1;
- otherwise it SHALL increment and us_tck SHALL be registered to 0.
REQ-016 The ms counter (16 bits) SHALL behave identically against MS-1, independently of the us counter, driving ms_tck.
REQ-017 Tick period SHALL be exactly US (MS) cycles; the first tick SHALL be asserted after the US-th (MS-th) enabled edge.
REQ-018 US or MS equal to 0 or 1 SHALL hold the corresponding tick continuously high while enabled.
REQ-019 When both counters wrap on the same edge, both ticks SHALL assert together with no interaction.
REQ-020 Counters SHALL never exceed parameter-1; there is no overflow path.

Reset
REQ-021 rst low SHALL asynchronously clear all counters.
REQ-022 rst low SHALL asynchronously force pll_locked, pll_outclk_0, us_tck and ms_tck to 0.
REQ-023 rst asserted mid-operation SHALL abort any pending tick immediately.
REQ-024 After rst deasserts, the lock and tick sequences SHALL restart from count 0.

Configuration
REQ-025 When macro CLOCKS_LOCK_GATE_EN is defined, the us and ms counters SHALL be enabled only while pll_locked is high and SHALL be held at 0, ticks at 0, before lock.
REQ-026 When CLOCKS_LOCK_GATE_EN is undefined, the us and ms counters SHALL be enabled on every edge from reset release, independent of pll_locked.

Verification
REQ-027 The bench SHALL run with clk period 20 ns, US=5, MS=10, LOCK_CYCLES=4 and PCLK_HALF=1, and cover:
- Reset: rst=0 for 20 ns -> all outputs 0 throughout, including during clk edges.
- Lock: release rst -> pll_locked rises on the 5th rising edge (count 0..4), then pll_outclk_0 toggles every edge (40 ns period).
- Ticks, macro undefined: us_tck high for 20 ns every 100 ns, first after the 5th edge; ms_tck high every 200 ns, coincident with every second us_tck.
- Ticks, CLOCKS_LOCK_GATE_EN defined: first us_tck occurs 5 edges after pll_locked rises; ms_tck occurs 10 edges after pll_locked rises.
- Mid-run reset: pulse rst low between edges while us_tck=1 -> us_tck, ms_tck, pll_locked and pll_outclk_0 drop immediately; the lock sequence repeats in full.
- Degenerate: US=1 -> us_tck stays 1 after enable.

Source files
------------

// File: rtl/clocks.sv
// Clock and tick generator.
// - Behavioural PLL stand-in: lock counter raises pll_locked after
//   LOCK_CYCLES+1 edges, then pll_outclk_0 toggles every PCLK_HALF edges.
// - Free-running microsecond / millisecond tick pulses (us_tck, ms_tck).
// Optional build macro: CLOCKS_LOCK_GATE_EN
//   defined   -> tick counters run only while pll_locked is high
//   undefined -> tick counters run on every edge after reset release
module clocks #(
  parameter logic [5:0]  US          = 6'd50,
  parameter logic [15:0] MS          = 16'd50000,
  parameter logic [7:0]  LOCK_CYCLES = 8'd4,
  parameter logic [3:0]  PCLK_HALF   = 4'd1
) (
  input  logic clk,
  input  logic rst,
  output logic pll_locked,
  output logic pll_outclk_0,
  output logic us_tck,
  output logic ms_tck
);

  // Terminal counts. A period of 0 or 1 collapses to "wrap every edge",
  // which keeps the tick permanently high; PCLK_HALF=0 behaves as 1.
  localparam logic [5:0]  US_LAST   = (US <= 6'd1)  ? 6'd0  : US - 6'd1;
  localparam logic [15:0] MS_LAST   = (MS <= 16'd1) ? 16'd0 : MS - 16'd1;
  localparam logic [3:0]  HALF_LAST = (PCLK_HALF == 4'd0) ? 4'd0 : PCLK_HALF - 4'd1;

  logic [7:0]  lock_cnt_reg;
  logic        locked_reg;
  logic [3:0]  half_cnt_reg;
  logic        outclk_reg;
  logic [5:0]  us_cnt_reg;
  logic        us_tck_reg;
  logic [15:0] ms_cnt_reg;
  logic        ms_tck_reg;
  logic        tick_en;

  // Tick counters either wait for lock or run straight out of reset.
`ifdef CLOCKS_LOCK_GATE_EN
  assign tick_en = locked_reg;
`else
  assign tick_en = 1'b1;
`endif

  // Lock counter: counts edges from reset release until it reaches LOCK_CYCLES,
  // then freezes and holds pll_locked high until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_cnt_reg <= 8'd0;
      locked_reg   <= 1'b0;
    end else if (!locked_reg) begin
      if (lock_cnt_reg == LOCK_CYCLES) begin
        locked_reg <= 1'b1;
      end else begin
        lock_cnt_reg <= lock_cnt_reg + 8'd1;
      end
    end
  end

  // Pixel clock: held low until lock, then a registered 50% duty toggle
  // every PCLK_HALF edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_cnt_reg <= 4'd0;
      outclk_reg   <= 1'b0;
    end else if (!locked_reg) begin
      half_cnt_reg <= 4'd0;
      outclk_reg   <= 1'b0;
    end else if (half_cnt_reg == HALF_LAST) begin
      half_cnt_reg <= 4'd0;
      outclk_reg   <= ~outclk_reg;
    end else begin
      half_cnt_reg <= half_cnt_reg + 4'd1;
    end
  end

  // Microsecond tick: wraps at US-1 and pulses for the cycle after the wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      us_cnt_reg <= 6'd0;
      us_tck_reg <= 1'b0;
    end else if (!tick_en) begin
      us_cnt_reg <= 6'd0;
      us_tck_reg <= 1'b0;
    end else if (us_cnt_reg == US_LAST) begin
      us_cnt_reg <= 6'd0;
      us_tck_reg <= 1'b1;
    end else begin
      us_cnt_reg <= us_cnt_reg + 6'd1;
      us_tck_reg <= 1'b0;
    end
  end

  // Millisecond tick: same scheme against MS-1, independent of the us counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ms_cnt_reg <= 16'd0;
      ms_tck_reg <= 1'b0;
    end else if (!tick_en) begin
      ms_cnt_reg <= 16'd0;
      ms_tck_reg <= 1'b0;
    end else if (ms_cnt_reg == MS_LAST) begin
      ms_cnt_reg <= 16'd0;
      ms_tck_reg <= 1'b1;
    end else begin
      ms_cnt_reg <= ms_cnt_reg + 16'd1;
      ms_tck_reg <= 1'b0;
    end
  end

  assign pll_locked   = locked_reg;
  assign pll_outclk_0 = outclk_reg;
  assign us_tck       = us_tck_reg;
  assign ms_tck       = ms_tck_reg;

endmodule

// File: tb/tb_clocks.sv
// Self-checking bench for clocks: two instances (nominal and degenerate
// parameters) compared every cycle against an edge-count based model.
module tb_clocks;

`ifdef CLOCKS_LOCK_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic a_locked, a_outclk, a_us, a_ms;
  logic b_locked, b_outclk, b_us, b_ms;

  clocks #(.US(6'd5), .MS(16'd10), .LOCK_CYCLES(8'd4), .PCLK_HALF(4'd1)) dut_a (
    .clk(clk), .rst(rst),
    .pll_locked(a_locked), .pll_outclk_0(a_outclk), .us_tck(a_us), .ms_tck(a_ms)
  );

  clocks #(.US(6'd1), .MS(16'd0), .LOCK_CYCLES(8'd0), .PCLK_HALF(4'd0)) dut_b (
    .clk(clk), .rst(rst),
    .pll_locked(b_locked), .pll_outclk_0(b_outclk), .us_tck(b_us), .ms_tck(b_ms)
  );

  always #10 clk = ~clk;

  // Rising edges seen since the most recent reset release.
  int n;
  always @(posedge clk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= n + 1;
  end

  int tests = 0;
  int fails = 0;
  bit first_run = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b (edge %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  // Expected {locked, outclk, us, ms} after edge e of a run with the given parameters.
  function automatic logic [3:0] model(input int e, input int lc, input int u,
                                       input int m, input int ph);
    int php, toggles, en;
    logic lk, oc, ut, mt;
    php     = (ph == 0) ? 1 : ph;
    lk      = (e >= lc + 1);
    toggles = (e > lc + 1) ? (e - lc - 1) / php : 0;
    oc      = (toggles % 2) == 1;
    if (GATED) en = (e > lc + 1) ? e - lc - 1 : 0;
    else       en = e;
    ut = (u <= 1) ? (en >= 1) : (en >= 1 && (en % u) == 0);
    mt = (m <= 1) ? (en >= 1) : (en >= 1 && (en % m) == 0);
    return {lk, oc, ut, mt};
  endfunction

  // Every-cycle comparison against the model, plus hand-derived pins on the first run.
  always @(negedge clk) begin
    logic [3:0] ea, eb;
    ea = model(n, 4, 5, 10, 1);
    eb = model(n, 0, 1, 0, 0);
    check("a_locked", a_locked, ea[3]);
    check("a_outclk", a_outclk, ea[2]);
    check("a_us",     a_us,     ea[1]);
    check("a_ms",     a_ms,     ea[0]);
    check("b_locked", b_locked, eb[3]);
    check("b_outclk", b_outclk, eb[2]);
    check("b_us",     b_us,     eb[1]);
    check("b_ms",     b_ms,     eb[0]);
    if (first_run) begin
      case (n)
        1:  check("pin_b_us_e1", b_us, !GATED);
        2:  check("pin_b_us_e2", b_us, 1'b1);
        4:  check("pin_lock_e4", a_locked, 1'b0);
        5: begin
          check("pin_lock_e5", a_locked, 1'b1);
          check("pin_pclk_e5", a_outclk, 1'b0);
          check("pin_us_e5",   a_us, !GATED);
        end
        6:  check("pin_pclk_e6", a_outclk, 1'b1);
        7:  check("pin_pclk_e7", a_outclk, 1'b0);
        10: begin
          check("pin_us_e10", a_us, 1'b1);
          check("pin_ms_e10", a_ms, !GATED);
        end
        15: check("pin_ms_e15", a_ms, GATED);
        default: ;
      endcase
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_a_locked"}, a_locked, 1'b0);
    check({tag, "_a_outclk"}, a_outclk, 1'b0);
    check({tag, "_a_us"},     a_us,     1'b0);
    check({tag, "_a_ms"},     a_ms,     1'b0);
    check({tag, "_b_locked"}, b_locked, 1'b0);
    check({tag, "_b_us"},     b_us,     1'b0);
  endtask

  initial begin
    int w;
    // Reset held across a rising edge: outputs stay 0 at the edge itself.
    @(posedge clk);
    #1;
    check_all_zero("rst_edge");
    #14;                      // t = 25 ns, between edges
    first_run = 1'b1;
    rst = 1'b1;
    repeat (40) @(posedge clk);

    // Random run lengths, each ending in an asynchronous reset pulse while us_tck=1.
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(5, 40)) @(posedge clk);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!a_us && w < 20);
      check("wait_us_tck", a_us, 1'b1);
      #2;
      first_run = (k == 0) ? 1'b0 : first_run;
      rst = 1'b0;
      #1;
      check_all_zero("midrst");
      #4;
      rst = 1'b1;
      $display("[TB] reset pulse %0d applied at t=%0t after %0d wait cycles", k, $time, w);
      repeat (30) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
